gon_readout_scheduler: RTL and testbench
========================================

GON_READOUT_SCHEDULER -- requirements
Module: gon_readout_scheduler

Interface
REQ-001: The block SHALL have the parameter ROW_TAG_WIDTH, default 4, setting the row tag width.
REQ-002: The block SHALL have the parameter COL_TAG_WIDTH, default 4, setting the column tag width.
REQ-003: The block SHALL have the parameter NUM_OF_ROWS, default 12, setting the maximum PE rows.
REQ-004: The block SHALL have the parameter NUM_OF_COLS, default 14, setting the maximum PE columns.
REQ-005: The block SHALL have the parameter CNT_WIDTH, default 16, setting the words-per-PE and transfer-count width.
REQ-006: The block SHALL have the port link_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007: The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-008: The block SHALL have the port start, input, 1 bit: request a readout pass.
REQ-009: The block SHALL have the port num_rows, input, ROW_TAG_WIDTH bits: rows to read, valid range 1..NUM_OF_ROWS.
REQ-010: The block SHALL have the port num_cols, input, COL_TAG_WIDTH bits: columns to read, valid range 1..NUM_OF_COLS.
REQ-011: The block SHALL have the port words_per_pe, input, CNT_WIDTH bits: psum words per PE, valid when greater than 0.
REQ-012: The block SHALL have the port gon_ready, input, 1 bit: the ANDed network ready.
REQ-013: The block SHALL have the port sink_ready, input, 1 bit: the downstream buffer can accept a word.
REQ-014: The block SHALL have the port row_tag, output, ROW_TAG_WIDTH bits: the row currently addressed.
REQ-015: The block SHALL have the port col_tag, output, COL_TAG_WIDTH bits: the column currently addressed.
REQ-016: The block SHALL have the port enable_out, output, 1 bit: the network transfer enable; one word moves per cycle it is high.
REQ-017: The block SHALL have the ports busy, done and cfg_err, output, 1 bit each.
REQ-018: The block SHALL have the port xfer_count, output, CNT_WIDTH bits: words moved in the current or last pass.

Function
REQ-019: The block SHALL implement the states IDLE, ISSUE and DONE.
REQ-020: In IDLE, when start=1 and the configuration is valid, the block SHALL latch num_rows, num_cols and words_per_pe, clear row, column, word and xfer_count counters to 0, and move to ISSUE on the next edge.
REQ-021: In IDLE, when start=1 and any configuration field is out of range, the block SHALL pulse cfg_err high for exactly 1 cycle, remain in IDLE, and leave the counters unchanged.
REQ-022: In ISSUE, enable_out SHALL be driven combinationally as gon_ready AND sink_ready, and busy SHALL be 1.
REQ-023: A transfer is defined as a cycle with enable_out=1 in ISSUE; on each transfer the word counter and xfer_count SHALL increment by 1.
REQ-024: When a transfer occurs with the word counter at words_per_pe-1, the word counter SHALL clear and the column SHALL increment; when the column is at num_cols-1 it SHALL wrap to 0 and the row SHALL increment.
REQ-025: A transfer at the last row, last column and last word SHALL move the block to DONE; no further enable_out is asserted in that pass.
REQ-026: row_tag and col_tag SHALL equal the registered row and column counters and SHALL remain stable while no transfer occurs (stall).
REQ-027: The block SHALL hold DONE for 1 cycle with done=1 and busy=0, then return to IDLE; xfer_count SHALL hold its value until the next accepted start.
REQ-028: start asserted in ISSUE or DONE SHALL be ignored, with no error.
REQ-029: A pass SHALL move exactly num_rows*num_cols*words_per_pe words; the block SHALL NOT check xfer_count for overflow, and software SHALL keep that product below 2^CNT_WIDTH.
REQ-030: The minimum latency from start to done SHALL be 1 + N + 1 cycles, where N is the word total, when ready is held continuously high.

Reset
REQ-031: While reset=1 at a clock edge, the block SHALL enter IDLE and clear row_tag, col_tag, all counters and xfer_count to 0.
REQ-032: While reset=1 at a clock edge, busy, done and cfg_err SHALL be 0, and enable_out SHALL be 0 because it is gated by the ISSUE state.
REQ-033: A reset asserted mid-pass SHALL abort the pass immediately, with no done pulse.

Verification
REQ-034: The bench SHALL cover: num_rows=2, num_cols=3, words_per_pe=2, both readies held 1 -> 12 enables, tag sequence (0,0)(0,0)(0,1)(0,1)…(1,2)(1,2), done in cycle 14 after start, xfer_count=12.
REQ-035: The bench SHALL cover: same configuration with sink_ready toggling 1010… -> enable_out only on sink_ready=1 cycles, tags frozen on stall cycles, 12 transfers total.
REQ-036: The bench SHALL cover: num_cols=0 with start -> one cfg_err pulse, busy stays 0, no enable_out.
REQ-037: The bench SHALL cover: num_rows=12, num_cols=14, words_per_pe=1 -> 168 transfers, final tags (11,13), done asserted once.
REQ-038: The bench SHALL cover: reset asserted after 5 transfers -> next cycle in IDLE, tags 0, xfer_count 0, no done pulse.
REQ-039: The bench SHALL cover: start re-pulsed during ISSUE -> ignored, pass completes with the originally latched configuration.

Source files
------------

// File: rtl/gon_readout_scheduler.sv
// Readout scheduler for the global-on-chip network: walks row/column/word counters
// for a configured PE array and issues one network transfer per ready cycle.
module gon_readout_scheduler #(
    parameter int unsigned ROW_TAG_WIDTH = 4,
    parameter int unsigned COL_TAG_WIDTH = 4,
    parameter int unsigned NUM_OF_ROWS   = 12,
    parameter int unsigned NUM_OF_COLS   = 14,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                     link_clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ROW_TAG_WIDTH-1:0] num_rows,
    input  logic [COL_TAG_WIDTH-1:0] num_cols,
    input  logic [CNT_WIDTH-1:0]     words_per_pe,
    input  logic                     gon_ready,
    input  logic                     sink_ready,
    output logic [ROW_TAG_WIDTH-1:0] row_tag,
    output logic [COL_TAG_WIDTH-1:0] col_tag,
    output logic                     enable_out,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err,
    output logic [CNT_WIDTH-1:0]     xfer_count
);

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    state_e                   state_q, state_d;
    logic [ROW_TAG_WIDTH-1:0] row_q, row_d, rows_cfg_q, rows_cfg_d;
    logic [COL_TAG_WIDTH-1:0] col_q, col_d, cols_cfg_q, cols_cfg_d;
    logic [CNT_WIDTH-1:0]     word_q, word_d, wpp_q, wpp_d;
    logic [CNT_WIDTH-1:0]     xfer_q, xfer_d;
    logic                     cfg_err_q, cfg_err_d;

    logic cfg_valid;
    logic last_word, last_col, last_row;

    assign cfg_valid = (num_rows != '0) && (num_rows <= ROW_TAG_WIDTH'(NUM_OF_ROWS)) &&
                       (num_cols != '0) && (num_cols <= COL_TAG_WIDTH'(NUM_OF_COLS)) &&
                       (words_per_pe != '0);

    assign last_word = (word_q == wpp_q - CNT_WIDTH'(1));
    assign last_col  = (col_q == cols_cfg_q - COL_TAG_WIDTH'(1));
    assign last_row  = (row_q == rows_cfg_q - ROW_TAG_WIDTH'(1));

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        word_d     = word_q;
        xfer_d     = xfer_q;
        rows_cfg_d = rows_cfg_q;
        cols_cfg_d = cols_cfg_q;
        wpp_d      = wpp_q;
        cfg_err_d  = 1'b0;
        enable_out = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (cfg_valid) begin
                        rows_cfg_d = num_rows;
                        cols_cfg_d = num_cols;
                        wpp_d      = words_per_pe;
                        row_d      = '0;
                        col_d      = '0;
                        word_d     = '0;
                        xfer_d     = '0;
                        state_d    = StIssue;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StIssue: begin
                busy       = 1'b1;
                enable_out = gon_ready & sink_ready;
                if (enable_out) begin
                    xfer_d = xfer_q + CNT_WIDTH'(1);
                    if (!last_word) begin
                        word_d = word_q + CNT_WIDTH'(1);
                    end else if (last_col && last_row) begin
                        // Final word: tags stay on the last PE for observability.
                        word_d  = '0;
                        state_d = StDone;
                    end else if (last_col) begin
                        word_d = '0;
                        col_d  = '0;
                        row_d  = row_q + ROW_TAG_WIDTH'(1);
                    end else begin
                        word_d = '0;
                        col_d  = col_q + COL_TAG_WIDTH'(1);
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge link_clk) begin
        if (reset) begin
            state_q    <= StIdle;
            row_q      <= '0;
            col_q      <= '0;
            word_q     <= '0;
            xfer_q     <= '0;
            rows_cfg_q <= '0;
            cols_cfg_q <= '0;
            wpp_q      <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            word_q     <= word_d;
            xfer_q     <= xfer_d;
            rows_cfg_q <= rows_cfg_d;
            cols_cfg_q <= cols_cfg_d;
            wpp_q      <= wpp_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign row_tag    = row_q;
    assign col_tag    = col_q;
    assign xfer_count = xfer_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_gon_readout_scheduler.sv
// Directed bench for gon_readout_scheduler: hand-computed tags, counts and handshake timing.
module tb_gon_readout_scheduler;

    logic        link_clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  num_rows;
    logic [3:0]  num_cols;
    logic [15:0] words_per_pe;
    logic        gon_ready;
    logic        sink_ready;
    logic [3:0]  row_tag;
    logic [3:0]  col_tag;
    logic        enable_out;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic [15:0] xfer_count;

    int checks = 0;
    int errors = 0;
    int n;
    int dones;
    int done_at;
    int last_row;
    int last_col;
    logic exp_en;

    gon_readout_scheduler dut (
        .link_clk    (link_clk),
        .reset       (reset),
        .start       (start),
        .num_rows    (num_rows),
        .num_cols    (num_cols),
        .words_per_pe(words_per_pe),
        .gon_ready   (gon_ready),
        .sink_ready  (sink_ready),
        .row_tag     (row_tag),
        .col_tag     (col_tag),
        .enable_out  (enable_out),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .xfer_count  (xfer_count)
    );

    always #5 link_clk = ~link_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge link_clk);
        #1;
    endtask

    task automatic set_cfg(input int r, input int c, input int w);
        num_rows     = 4'(r);
        num_cols     = 4'(c);
        words_per_pe = 16'(w);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        gon_ready = 1'b1;
        sink_ready = 1'b1;
        set_cfg(2, 3, 2);
        cyc();
        cyc();
        #1;
        check("rst_row", row_tag, 0);
        check("rst_col", col_tag, 0);
        check("rst_en", enable_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", cfg_err, 0);
        check("rst_xfer", xfer_count, 0);
        reset = 1'b0;
        cyc();

        // Pass 1: 2x3x2, readies high; start is cycle 1, done lands in cycle 14.
        start = 1'b1;
        #1;
        check("p1_idle_busy", busy, 0);
        cyc();
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            #1;
            check("p1_en", enable_out, 1);
            check("p1_busy", busy, 1);
            check("p1_done", done, 0);
            check("p1_row", row_tag, k / 6);
            check("p1_col", col_tag, (k / 2) % 3);
            cyc();
        end
        #1;
        check("p1_done_c14", done, 1);
        check("p1_busy_c14", busy, 0);
        check("p1_en_c14", enable_out, 0);
        check("p1_xfer", xfer_count, 12);
        cyc();
        #1;
        check("p1_done_clr", done, 0);
        check("p1_xfer_hold", xfer_count, 12);

        // Pass 2: sink_ready toggling 1010...
        start = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            exp_en = (i % 2 == 0);
            sink_ready = exp_en;
            #1;
            check("p2_en", enable_out, exp_en);
            check("p2_row", row_tag, n / 6);
            check("p2_col", col_tag, (n / 2) % 3);
            check("p2_xfer", xfer_count, n);
            if (exp_en) n++;
            cyc();
            if (n == 12) break;
        end
        #1;
        check("p2_total", n, 12);
        check("p2_done", done, 1);
        check("p2_xfer_end", xfer_count, 12);
        sink_ready = 1'b1;
        cyc();

        // Invalid config: num_cols=0.
        set_cfg(2, 0, 2);
        start = 1'b1;
        #1;
        check("err_pre", cfg_err, 0);
        cyc();
        start = 1'b0;
        #1;
        check("err_pulse", cfg_err, 1);
        check("err_busy", busy, 0);
        check("err_en", enable_out, 0);
        check("err_xfer", xfer_count, 12);
        cyc();
        #1;
        check("err_clr", cfg_err, 0);
        check("err_busy2", busy, 0);
        check("err_en2", enable_out, 0);

        // Full array 12x14x1.
        set_cfg(12, 14, 1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        dones = 0;
        done_at = -1;
        last_row = -1;
        last_col = -1;
        for (int i = 0; i < 175; i++) begin
            #1;
            if (enable_out) begin
                n++;
                last_row = int'(row_tag);
                last_col = int'(col_tag);
            end
            if (done) begin
                dones++;
                done_at = i;
            end
            cyc();
        end
        check("full_xfers", n, 168);
        check("full_last_row", last_row, 11);
        check("full_last_col", last_col, 13);
        check("full_dones", dones, 1);
        check("full_done_at", done_at, 168);
        check("full_xfer_cnt", xfer_count, 168);

        // Reset after 5 transfers.
        set_cfg(2, 3, 2);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        #1;
        check("abort_xfer_pre", xfer_count, 5);
        check("abort_col_pre", col_tag, 2);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        check("abort_row", row_tag, 0);
        check("abort_col", col_tag, 0);
        check("abort_xfer", xfer_count, 0);
        check("abort_busy", busy, 0);
        check("abort_en", enable_out, 0);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) dones++;
            cyc();
            #1;
        end
        check("abort_no_done", dones, 0);

        // Start re-pulsed mid-pass with a different config must be ignored.
        set_cfg(1, 2, 3);
        start = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            start = (i == 1 || i == 2);
            if (i == 1) set_cfg(2, 3, 2);
            #1;
            if (enable_out) begin
                check("rep_row", row_tag, 0);
                check("rep_col", col_tag, n / 3);
                n++;
            end
            if (done) begin
                dones++;
                break;
            end
            cyc();
        end
        start = 1'b0;
        check("rep_total", n, 6);
        check("rep_done", dones, 1);
        check("rep_xfer", xfer_count, 6);
        cyc();
        #1;
        check("rep_idle_busy", busy, 0);
        check("rep_idle_done", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
